// File: rtl/systolic_edge_feeder_pkg.sv
// ============================================================================
// Module      : systolic_edge_feeder_pkg
// Description : Shared definitions for the systolic edge feeder: FP zero
//               pattern, FSM state encoding and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FPZero
`define FPZero 32'h0000_0000
`endif

`ifndef SYSTOLIC_EDGE_FEEDER_PKG_SV
`define SYSTOLIC_EDGE_FEEDER_PKG_SV

package systolic_edge_feeder_pkg;

  // Feeder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ARM    = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/systolic_edge_feeder_if.sv
// ============================================================================
// Module      : systolic_edge_feeder_if
// Description : Load/stream bus of the systolic edge feeder.
//               master : producer of vectors + GO, consumer of edge lanes
//               slave  : the feeder itself
//   IN_VALID/IN_READY/IN_DATA : vector load handshake (lane i = [i*DW +: DW])
//   GO / ARMED                : start request / frame loaded
//   EDGE_OUT/EDGE_VALID/DONE  : skewed lanes, step valid, end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_edge_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [N*DW-1:0] IN_DATA;
  logic            GO;
  logic            ARMED;
  logic [N*DW-1:0] EDGE_OUT;
  logic            EDGE_VALID;
  logic            DONE;

  modport master (
    output IN_VALID, IN_DATA, GO,
    input  IN_READY, ARMED, EDGE_OUT, EDGE_VALID, DONE
  );

  modport slave (
    input  IN_VALID, IN_DATA, GO,
    output IN_READY, ARMED, EDGE_OUT, EDGE_VALID, DONE
  );
endinterface

`default_nettype wire

// File: rtl/systolic_edge_feeder_skew_lane_mux.sv
// ============================================================================
// Module      : skew_lane_mux
// Description : Combinational skew select for one edge lane. For step i_step
//               the lane carries column entry (i_step - LANE) when that index
//               lies in 0..K-1, otherwise exact FP zero.
//   i_step : current stream step
//   i_col  : this lane's element of every buffered vector
//   o_lane : lane value for the step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_lane_mux #(
  parameter int LANE = 0,
  parameter int K    = 4,
  parameter int DW   = 32,
  parameter int SW   = 3
) (
  input  logic [SW-1:0] i_step,
  input  logic [DW-1:0] i_col [K],
  output logic [DW-1:0] o_lane
);

  // Matching i_step against LANE+k avoids a signed subtraction and keeps
  // the out-of-window case naturally at zero.
  always_comb begin
    o_lane = DW'(`FPZero);
    for (int k = 0; k < K; k++) begin
      if (32'(i_step) == 32'(LANE + k)) begin
        o_lane = i_col[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_edge_feeder.sv
// ============================================================================
// Module      : systolic_edge_feeder
// Description : Transmit side of the PE edge interface. Buffers a K-vector
//               frame, then on GO streams it to N edge lanes with diagonal
//               skew (lane i delayed i steps, idle slots FP zero).
//   CLK   : clock, rising edge
//   RST_N : asynchronous reset, active low
//   feed  : load/stream bus (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_edge_feeder
  import systolic_edge_feeder_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = 32
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  systolic_edge_feeder_if.slave  feed
);

  localparam int c_STEPS = K + N - 1;
  localparam int c_LW    = (clog2(K) < 1) ? 1 : clog2(K);
  localparam int c_SW    = (clog2(c_STEPS) < 1) ? 1 : clog2(c_STEPS);

  state_t                 r_state;
  logic [c_LW-1:0]        r_load_idx;
  logic [c_SW-1:0]        r_step;
  logic                   r_last;
  logic                   r_in_ready;
  logic                   r_armed;
  logic                   r_edge_valid;
  logic                   r_done;
  logic [N*DW-1:0]        r_edge_out;
  logic [N-1:0][DW-1:0]   r_buf [K];

  logic                   w_beat;
  logic [N*DW-1:0]        w_skew;

  assign w_beat = feed.IN_VALID & r_in_ready;

  // Frame buffer: contents are irrelevant until fully loaded, so no reset.
  // r_load_idx is 0 in IDLE, which places the first beat at BUF[0].
  always_ff @(posedge CLK) begin
    for (int k = 0; k < K; k++) begin
      if (w_beat && (r_load_idx == c_LW'(k))) begin
        r_buf[k] <= feed.IN_DATA;
      end
    end
  end

  // One skew mux per lane, fed with that lane's column of the buffer
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] w_col [K];
      for (genvar k = 0; k < K; k++) begin : g_col
        assign w_col[k] = r_buf[k][i];
      end
      skew_lane_mux #(
        .LANE (i),
        .K    (K),
        .DW   (DW),
        .SW   (c_SW)
      ) u_mux (
        .i_step (r_step),
        .i_col  (w_col),
        .o_lane (w_skew[i*DW +: DW])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_load_idx   <= '0;
      r_step       <= '0;
      r_last       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_armed      <= 1'b0;
      r_edge_valid <= 1'b0;
      r_done       <= 1'b0;
      r_edge_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            if (K == 1) begin
              r_state    <= ST_ARM;
              r_in_ready <= 1'b0;
              r_armed    <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_load_idx <= c_LW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            if (r_load_idx == c_LW'(K - 1)) begin
              r_state    <= ST_ARM;
              r_load_idx <= '0;
              r_in_ready <= 1'b0;
              r_armed    <= 1'b1;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (feed.GO) begin
            r_state <= ST_STREAM;
            r_armed <= 1'b0;
            r_step  <= '0;
            r_last  <= 1'b0;
          end
        end
        ST_STREAM: begin
          // r_last marks that step S-1 is already on the outputs, so the
          // step counter never has to count past S-1.
          if (r_last) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b1;
            r_edge_out   <= '0;
            r_edge_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_step       <= '0;
            r_last       <= 1'b0;
          end else begin
            r_edge_out   <= w_skew;
            r_edge_valid <= 1'b1;
            if (r_step == c_SW'(c_STEPS - 1)) begin
              r_last <= 1'b1;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign feed.IN_READY   = r_in_ready;
  assign feed.ARMED      = r_armed;
  assign feed.EDGE_OUT   = r_edge_out;
  assign feed.EDGE_VALID = r_edge_valid;
  assign feed.DONE       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_systolic_edge_feeder.sv
// ============================================================================
// Module      : tb_systolic_edge_feeder
// Description : Self-checking bench for systolic_edge_feeder. Stimulus pushes
//               expected skewed steps into a queue; a negedge monitor pops
//               and compares them against EDGE_OUT/EDGE_VALID/DONE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_edge_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 32;
  localparam int S  = K + N - 1;

  typedef struct {
    logic [N*DW-1:0] data;
    int              cyc;
    bit              last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  systolic_edge_feeder_if #(.N(N), .DW(DW)) fif ();

  systolic_edge_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .feed  (fif)
  );

  exp_t          q[$];
  exp_t          m_e;
  int            total    = 0;
  int            bad      = 0;
  int            cyc      = 0;
  int            done_cyc = -1;
  logic [DW-1:0] frame [K][N];
  logic [DW-1:0] fp_val [4];
  bit            vpat [7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [N*DW-1:0] act,
                                input logic [N*DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Scoreboard monitor: every cycle either an expected step is due, or the
  // lanes must be idle; DONE only in the cycle after the last step.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        m_e = q.pop_front();
        check("edge_valid", {127'd0, fif.EDGE_VALID}, 1);
        check("edge_out", fif.EDGE_OUT, m_e.data);
        if (m_e.last) done_cyc = cyc + 1;
      end else begin
        check("edge_valid_idle", {127'd0, fif.EDGE_VALID}, 0);
      end
      if (cyc == done_cyc) begin
        check("done_pulse", {127'd0, fif.DONE}, 1);
        check("edge_out_cleared", fif.EDGE_OUT, 0);
        check("ready_on_done", {127'd0, fif.IN_READY}, 1);
      end else begin
        check("done_quiet", {127'd0, fif.DONE}, 0);
      end
    end
  end

  // Load one frame with random (or fixed) IN_VALID gaps and random GO noise.
  task automatic load_frame(input bit fixed);
    int              j;
    int              p;
    int              guard;
    bit              v;
    logic [N*DW-1:0] vec;
    j = 0; p = 0; guard = 0;
    while (j < K && guard < 300) begin
      @(negedge clk);
      guard++;
      check("armed_during_load", {127'd0, fif.ARMED}, 0);
      if (fixed) begin
        v = vpat[p % 7];
        p++;
      end else begin
        v = ($urandom_range(0, 2) != 0);
      end
      fif.GO = ($urandom_range(0, 3) == 0);
      if (v && fif.IN_READY) begin
        if (fixed) vec = {N{fp_val[j]}};
        else       vec = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < N; i++) frame[j][i] = vec[i*DW +: DW];
        fif.IN_VALID = 1'b1;
        fif.IN_DATA  = vec;
        j++;
      end else begin
        fif.IN_VALID = v;
        fif.IN_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    check("load_beats", 128'(j), 128'(K));
    @(negedge clk);
    fif.GO       = 1'b0;
    fif.IN_VALID = 1'b1;   // must be ignored while armed
    fif.IN_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("armed_after_load", {127'd0, fif.ARMED}, 1);
    check("ready_while_armed", {127'd0, fif.IN_READY}, 0);
  endtask

  // Raise GO in ARM and enqueue the expected skewed steps of the frame.
  task automatic go_frame(input int hold, output int c0);
    logic [N*DW-1:0] d;
    int              k;
    @(negedge clk);
    check("armed_before_go", {127'd0, fif.ARMED}, 1);
    fif.GO       = 1'b1;
    fif.IN_VALID = 1'b0;
    c0 = cyc;
    for (int s = 0; s < S; s++) begin
      d = '0;
      for (int i = 0; i < N; i++) begin
        k = s - i;
        if (k >= 0 && k < K) d[i*DW +: DW] = frame[k][i];
      end
      q.push_back('{data: d, cyc: c0 + 2 + s, last: (s == S - 1)});
    end
    repeat (hold) @(negedge clk);
    fif.GO = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() > 0 || done_cyc >= cyc) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue_empty", 128'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    fp_val[0] = 32'h3F80_0000;
    fp_val[1] = 32'h4000_0000;
    fp_val[2] = 32'h4040_0000;
    fp_val[3] = 32'h4080_0000;
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
    vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
    fif.IN_VALID = 1'b0;
    fif.IN_DATA  = '0;
    fif.GO       = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", {127'd0, fif.IN_READY}, 0);
    check("rst_armed", {127'd0, fif.ARMED}, 0);
    check("rst_edge_out", fif.EDGE_OUT, 0);
    check("rst_edge_valid", {127'd0, fif.EDGE_VALID}, 0);
    check("rst_done", {127'd0, fif.DONE}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", {127'd0, fif.IN_READY}, 0);
    @(negedge clk);
    check("ready_after_first_edge", {127'd0, fif.IN_READY}, 1);

    // Fixed 1.0..4.0 frame with the 1,0,0,1,1,0,1 valid pattern
    load_frame(1'b1);
    go_frame(1, c0);

    // Random frames; loads overlap the previous stream, one GO held 20 cycles
    for (int f = 0; f < 8; f++) begin
      load_frame(1'b0);
      go_frame((f == 2) ? 20 : $urandom_range(1, 6), c0);
    end

    // Reset in the middle of a stream (step 3 on the outputs)
    load_frame(1'b0);
    go_frame(1, c0);
    while (cyc != c0 + 5) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_edge_out", fif.EDGE_OUT, 0);
    check("midrst_edge_valid", {127'd0, fif.EDGE_VALID}, 0);
    check("midrst_in_ready", {127'd0, fif.IN_READY}, 0);
    check("midrst_armed", {127'd0, fif.ARMED}, 0);
    q.delete();
    done_cyc = -1;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midrst", {127'd0, fif.IN_READY}, 1);

    // Fresh frames after the abandoned one
    for (int f = 0; f < 2; f++) begin
      load_frame(1'b0);
      go_frame($urandom_range(1, 4), c0);
    end
    fif.IN_VALID = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
